// File: rtl/wb_console_mon.sv
// wb_console_mon
// Console monitor that snoops the CPU data-memory Wishbone bus. Byte writes to
// the console register are captured into a show-ahead FIFO, a rolling 4-byte
// window is matched against a pass and a fail string, and a watchdog flags a
// program that stops printing. Status outputs drive bench exit or board LEDs.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   wb_adr_i/sel_i/stb_i    snooped register address, region select, strobe
//   wb_we_i, wb_dat_i       write enable, write data low byte
//   rd_i                    pop FIFO head
//   rdat_o                  FIFO head byte (0 when empty)
//   empty_o, full_o         FIFO status
//   overflow_o              sticky: a captured byte was dropped
//   char_cnt_o              captured-byte count, saturating
//   pass_o, fail_o          sticky pattern-match flags
//   timeout_o               sticky watchdog flag
//   busy_o                  high while still running
//   state_o                 FSM state (RUN=0, PASS=1, FAIL=2, TIMEOUT=3)
//
// Handshake: a capture is one event per rising edge of wb_stb_i (qualified by
// sel/we/address); there is no back-pressure toward the bus. A FIFO read
// completes on any clock edge where rd_i=1 and empty_o=0; rdat_o is the head
// before that edge.
module wb_console_mon #(
  parameter int          ADR_W      = 5,
  parameter int          CON_ADR    = 0,
  parameter int          FIFO_DEPTH = 16,
  parameter int          PASS_LEN   = 4,
  parameter logic [31:0] PASS_PAT   = "DONE",
  parameter int          FAIL_LEN   = 3,
  parameter logic [31:0] FAIL_PAT   = "ERR",
  parameter int          TIMEOUT    = 600000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADR_W-1:0] wb_adr_i,
  input  logic             wb_sel_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [7:0]       wb_dat_i,
  input  logic             rd_i,
  output logic [7:0]       rdat_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o,
  output logic [15:0]      char_cnt_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic             busy_o,
  output logic [1:0]       state_o
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int PB   = 8 * PASS_LEN;
  localparam int FB   = 8 * FAIL_LEN;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic            stb_q;
  logic            cap_ev, cap, cap_q;
  logic [31:0]     window;
  logic [WD_W-1:0] wdog;
  logic            wd_hit, pass_hit, fail_hit;
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [7:0]      mem [FIFO_DEPTH];
  logic            push, pop;

  // Rising-edge strobe qualification: a held strobe captures only once.
  assign cap_ev = wb_sel_i & wb_we_i & wb_stb_i & ~stb_q &
                  (wb_adr_i == ADR_W'(CON_ADR));
  assign cap    = cap_ev & (state == ST_RUN);

  // Matching looks at the window register, so it only means something on the
  // cycle right after a capture updated it (cap_q).
  assign pass_hit = cap_q & (window[PB-1:0] == PASS_PAT[PB-1:0]);
  assign fail_hit = cap_q & (window[FB-1:0] == FAIL_PAT[FB-1:0]);

  // A capture on the last watchdog cycle rescues the run.
  assign wd_hit = (TIMEOUT != 0) & (state == ST_RUN) & ~cap & (wdog == WD_LAST);

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = rd_i & ~empty_o;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push    = cap & (~full_o | pop);
  assign rdat_o  = empty_o ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    pass_o    = 1'b0;
    fail_o    = 1'b0;
    timeout_o = 1'b0;
    state_o   = state;
    case (state)
      ST_RUN: begin
        busy_o = 1'b1;
        if (fail_hit)      state_nxt = ST_FAIL;   // fail wins a tie
        else if (pass_hit) state_nxt = ST_PASS;
        else if (wd_hit)   state_nxt = ST_TIMEOUT;
      end
      ST_PASS:    pass_o    = 1'b1;
      ST_FAIL:    fail_o    = 1'b1;
      ST_TIMEOUT: timeout_o = 1'b1;
      default:    state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_RUN;
      stb_q      <= 1'b0;
      cap_q      <= 1'b0;
      window     <= '0;
      wdog       <= '0;
      char_cnt_o <= '0;
      overflow_o <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state <= state_nxt;
      stb_q <= wb_stb_i;
      cap_q <= cap;
      if (cap) begin
        window <= {window[23:0], wb_dat_i};
        if (char_cnt_o != 16'hFFFF) char_cnt_o <= char_cnt_o + 16'd1;
        if (!push) overflow_o <= 1'b1;
      end
      if ((TIMEOUT != 0) && (state == ST_RUN)) begin
        if (cap)          wdog <= '0;
        else if (!wd_hit) wdog <= wdog + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are only visible through rdat_o when
  // the pointers say the entry is live.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wb_dat_i;
  end

endmodule

// File: tb/tb_wb_console_mon.sv
module tb_wb_console_mon;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] adr;
  logic       sel, stb, we, rd;
  logic [7:0] dat;

  logic [7:0]  a_rdat, b_rdat;
  logic        a_empty, a_full, a_ovf, a_pass, a_fail, a_tmo, a_busy;
  logic        b_empty, b_full, b_ovf, b_pass, b_fail, b_tmo, b_busy;
  logic [15:0] a_cnt, b_cnt;
  logic [1:0]  a_state, b_state;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  // dut_a: small FIFO and short watchdog; default pass/fail strings
  wb_console_mon #(.FIFO_DEPTH(4), .TIMEOUT(50)) dut_a (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_sel_i(sel), .wb_stb_i(stb),
    .wb_we_i(we), .wb_dat_i(dat), .rd_i(rd), .rdat_o(a_rdat), .empty_o(a_empty),
    .full_o(a_full), .overflow_o(a_ovf), .char_cnt_o(a_cnt), .pass_o(a_pass),
    .fail_o(a_fail), .timeout_o(a_tmo), .busy_o(a_busy), .state_o(a_state));

  // dut_b: pass "R" and fail "ER" both match on the same byte of "ER"
  wb_console_mon #(.FIFO_DEPTH(4), .PASS_LEN(1), .PASS_PAT(32'h0000_0052),
                   .FAIL_LEN(2), .FAIL_PAT(32'h0000_4552), .TIMEOUT(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_sel_i(sel), .wb_stb_i(stb),
    .wb_we_i(we), .wb_dat_i(dat), .rd_i(rd), .rdat_o(b_rdat), .empty_o(b_empty),
    .full_o(b_full), .overflow_o(b_ovf), .char_cnt_o(b_cnt), .pass_o(b_pass),
    .fail_o(b_fail), .timeout_o(b_tmo), .busy_o(b_busy), .state_o(b_state));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; sel = 1'b0; stb = 1'b0; we = 1'b0; rd = 1'b0; adr = '0; dat = '0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic s, input logic [7:0] d, input bit expect_push);
    @(negedge clk);
    adr = a; sel = s; we = 1'b1; stb = 1'b1; dat = d;
    if (expect_push) exp_q.push_back(d);
    @(negedge clk);
    stb = 1'b0; we = 1'b0; sel = 1'b0;
  endtask

  task automatic wr_con(input logic [7:0] d, input bit expect_push);
    wr(5'd0, 1'b1, d, expect_push);
  endtask

  // scoreboard pop: head must be non-empty and equal the oldest expected byte
  task automatic pop_chk(input string tag);
    @(negedge clk);
    chk({tag, "_nonempty"}, 32'(a_empty), 32'd0);
    if (exp_q.size() != 0) chk(tag, 32'(a_rdat), 32'(exp_q.pop_front()));
    else begin
      checks++; errors++;
      $error("FAIL %s observed=pop expected=no_pending_byte", tag);
    end
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"}, 32'(a_empty), 32'd1);
    chk({tag, "_full"},  32'(a_full),  32'd0);
    chk({tag, "_rdat"},  32'(a_rdat),  32'd0);
    chk({tag, "_cnt"},   32'(a_cnt),   32'd0);
    chk({tag, "_busy"},  32'(a_busy),  32'd1);
    chk({tag, "_flags"}, {28'd0, a_pass, a_fail, a_tmo, a_ovf}, 32'd0);
    chk({tag, "_b_flags"}, {28'd0, b_pass, b_fail, b_tmo, b_ovf}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; stb = 1'b0; we = 1'b0; rd = 1'b0; adr = '0; dat = '0;
    #1;
    chk_idle("reset");

    // "HI"
    do_reset();
    chk_idle("post_reset");
    wr_con(8'h48, 1'b1);
    wr_con(8'h49, 1'b1);
    chk("hi_cnt", 32'(a_cnt), 32'd2);
    pop_chk("hi_pop0");
    pop_chk("hi_pop1");
    chk("hi_empty", 32'(a_empty), 32'd1);
    chk("hi_busy", 32'(a_busy), 32'd1);
    chk("hi_flags", {29'd0, a_pass, a_fail, a_tmo}, 32'd0);

    // "XDONE" then a dropped "Z"
    do_reset();
    wr_con("X", 1'b1); pop_chk("xd_pop_x");
    wr_con("D", 1'b1); pop_chk("xd_pop_d");
    wr_con("O", 1'b1); pop_chk("xd_pop_o");
    wr_con("N", 1'b1); pop_chk("xd_pop_n");
    wr_con("E", 1'b1);
    chk("xd_pass_lat1", 32'(a_pass), 32'd0);
    @(negedge clk);
    chk("xd_pass_lat2", 32'(a_pass), 32'd1);
    chk("xd_busy", 32'(a_busy), 32'd0);
    chk("xd_fail", 32'(a_fail), 32'd0);
    pop_chk("xd_pop_e");
    wr_con("Z", 1'b0);
    chk("xd_cnt", 32'(a_cnt), 32'd5);
    chk("xd_z_empty", 32'(a_empty), 32'd1);

    // "ERR"; dut_b ties pass/fail on "ER"
    do_reset();
    wr_con("E", 1'b1); pop_chk("err_pop_e");
    wr_con("R", 1'b1); pop_chk("err_pop_r0");
    wr_con("R", 1'b1);
    chk("err_fail_lat1", 32'(a_fail), 32'd0);
    @(negedge clk);
    chk("err_fail", 32'(a_fail), 32'd1);
    chk("err_pass", 32'(a_pass), 32'd0);
    chk("tie_fail", 32'(b_fail), 32'd1);
    chk("tie_pass", 32'(b_pass), 32'd0);
    pop_chk("err_pop_r1");

    // held strobe, wrong address, region not selected
    do_reset();
    @(negedge clk);
    adr = 5'd0; sel = 1'b1; we = 1'b1; stb = 1'b1; dat = 8'h5A;
    exp_q.push_back(8'h5A);
    repeat (10) @(negedge clk);
    stb = 1'b0; we = 1'b0; sel = 1'b0;
    chk("hold_cnt", 32'(a_cnt), 32'd1);
    wr(5'd1, 1'b1, 8'h11, 1'b0);
    wr(5'd0, 1'b0, 8'h22, 1'b0);
    chk("nocap_cnt", 32'(a_cnt), 32'd1);
    pop_chk("hold_pop");
    chk("nocap_empty", 32'(a_empty), 32'd1);

    // overflow: 6 bytes into a 4-deep FIFO
    do_reset();
    for (int i = 0; i < 4; i++) wr_con(8'h10 + 8'(i), 1'b1);
    chk("ovf_full", 32'(a_full), 32'd1);
    chk("ovf_pre", 32'(a_ovf), 32'd0);
    wr_con(8'h14, 1'b0);
    chk("ovf_set", 32'(a_ovf), 32'd1);
    wr_con(8'h15, 1'b0);
    chk("ovf_cnt", 32'(a_cnt), 32'd6);
    for (int i = 0; i < 4; i++) pop_chk("ovf_pop");
    chk("ovf_drained", 32'(a_empty), 32'd1);

    // push and pop on the same edge while full
    do_reset();
    for (int i = 0; i < 4; i++) wr_con(8'h20 + 8'(i), 1'b1);
    @(negedge clk);
    chk("pp_head", 32'(a_rdat), 32'(exp_q.pop_front()));
    adr = 5'd0; sel = 1'b1; we = 1'b1; stb = 1'b1; dat = 8'h24; rd = 1'b1;
    exp_q.push_back(8'h24);
    @(negedge clk);
    stb = 1'b0; we = 1'b0; sel = 1'b0; rd = 1'b0;
    chk("pp_full", 32'(a_full), 32'd1);
    chk("pp_ovf", 32'(a_ovf), 32'd0);
    chk("pp_cnt", 32'(a_cnt), 32'd5);
    for (int i = 0; i < 4; i++) pop_chk("pp_pop");

    // watchdog with no writes
    do_reset();
    repeat (49) @(negedge clk);
    chk("wd_49", 32'(a_tmo), 32'd0);
    @(negedge clk);
    chk("wd_50", 32'(a_tmo), 32'd1);
    chk("wd_busy", 32'(a_busy), 32'd0);
    chk("wd_b_off", 32'(b_tmo), 32'd0);

    // a write every 40 cycles keeps the watchdog quiet
    do_reset();
    for (int i = 0; i < 4; i++) begin
      repeat (38) @(negedge clk);
      chk("wd_kept", 32'(a_tmo), 32'd0);
      wr_con(8'h30 + 8'(i), 1'b1);
    end
    chk("wd_kept_cnt", 32'(a_cnt), 32'd4);
    repeat (49) @(negedge clk);
    chk("wd_last_49", 32'(a_tmo), 32'd0);
    @(negedge clk);
    chk("wd_last_50", 32'(a_tmo), 32'd1);
    chk("wd_full", 32'(a_full), 32'd1);

    // reset mid-run clears everything without waiting for a clock edge
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk_idle("midrst");
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
